sram_port_arbiter: RTL and testbench

- Shares one SRAM-like memory port between two requesters: the instruction fetch path (IF) and the data access path (EX issues, MEM consumes data_rdata).
- Sits between the pipeline and the bridge or cache, and serialises transactions with exactly one outstanding transaction at a time.
- Requester handshake is req / addr_ok / data_ok; requesters hold their request until addr_ok.

---
 rtl/sram_port_arbiter_pkg.sv | 16 +
 rtl/sram_port_arbiter_req_mux.sv | 51 +++++
 rtl/sram_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings and defaults for the two-requester SRAM port arbiter.
package sram_port_arbiter_pkg;

  localparam int ARB_ADDR_W_DEF = 32;
  localparam int ARB_DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/sram_port_arbiter_req_mux.sv
// Winner select and request field mux for the SRAM port arbiter.
// With ARB_RR_EN defined, collisions alternate using the last_grant input.
module sram_port_arbiter_req_mux
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W_DEF,
  parameter int DATA_W = ARB_DATA_W_DEF
) (
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
`ifdef ARB_RR_EN
  input  logic              last_grant,
`endif
  output logic              grant_vld,
  output logic              grant_owner,
  output logic              grant_wr,
  output logic [3:0]        grant_wstrb,
  output logic [ADDR_W-1:0] grant_addr,
  output logic [DATA_W-1:0] grant_wdata
);

  logic sel_data;

`ifdef ARB_RR_EN
  // On a collision the requester that did not win last time goes first.
  assign sel_data = data_req && (!inst_req || (last_grant == OWN_INST));
`else
  assign sel_data = data_req;
`endif

  always_comb begin
    grant_vld   = inst_req | data_req;
    grant_owner = sel_data ? OWN_DATA : OWN_INST;
    grant_wr    = 1'b0;
    grant_wstrb = 4'b0000;
    grant_addr  = inst_addr;
    grant_wdata = '0;
    if (sel_data) begin
      grant_wr    = data_wr;
      grant_wstrb = data_wstrb;
      grant_addr  = data_addr;
      grant_wdata = data_wdata;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Serialises IF and data requests onto one SRAM-like port, one transaction at a time.
// Optional macro ARB_RR_EN switches collisions from data-first to round-robin.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W_DEF,
  parameter int DATA_W = ARB_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              discard_q, discard_d;
  logic              wr_q, wr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              grant_vld;
  logic              grant_owner;
  logic              grant_wr;
  logic [3:0]        grant_wstrb;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_wdata;

`ifdef ARB_RR_EN
  logic last_grant_q, last_grant_d;
`endif

  sram_port_arbiter_req_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_req_mux (
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .data_req   (data_req),
    .data_wr    (data_wr),
    .data_wstrb (data_wstrb),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
`ifdef ARB_RR_EN
    .last_grant (last_grant_q),
`endif
    .grant_vld  (grant_vld),
    .grant_owner(grant_owner),
    .grant_wr   (grant_wr),
    .grant_wstrb(grant_wstrb),
    .grant_addr (grant_addr),
    .grant_wdata(grant_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_INST;
      discard_q <= 1'b0;
      wr_q      <= 1'b0;
      wstrb_q   <= 4'b0000;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      discard_q <= discard_d;
      wr_q      <= wr_d;
      wstrb_q   <= wstrb_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= OWN_INST;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // A flush aimed at the in-flight fetch suppresses handshakes in the same cycle
  // as well as for the rest of the transaction (via discard_q).
  logic inst_kill;
  assign inst_kill = (owner_q == OWN_INST) && (discard_q || flush);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    discard_d    = discard_q;
    wr_d         = wr_q;
    wstrb_d      = wstrb_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    bus_req      = 1'b0;
    bus_wr       = 1'b0;
    bus_wstrb    = 4'b0000;
    bus_addr     = '0;
    bus_wdata    = '0;

    case (state_q)
      ARB_IDLE: begin
        discard_d = 1'b0;
        if (grant_vld) begin
          state_d = ARB_ADDR;
          owner_d = grant_owner;
          wr_d    = grant_wr;
          wstrb_d = grant_wstrb;
          addr_d  = grant_addr;
          wdata_d = grant_wdata;
`ifdef ARB_RR_EN
          last_grant_d = grant_owner;
`endif
        end
      end
      ARB_ADDR: begin
        bus_req   = 1'b1;
        bus_wr    = wr_q;
        bus_wstrb = wstrb_q;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        if (inst_kill) begin
          discard_d = 1'b1;
        end
        if (bus_addr_ok) begin
          state_d = ARB_RESP;
          if (owner_q == OWN_DATA) begin
            data_addr_ok = 1'b1;
          end else begin
            inst_addr_ok = !inst_kill;
          end
        end
      end
      ARB_RESP: begin
        if (inst_kill) begin
          discard_d = 1'b1;
        end
        if (bus_data_ok) begin
          state_d   = ARB_IDLE;
          discard_d = 1'b0;
          if (owner_q == OWN_DATA) begin
            data_data_ok = 1'b1;
          end else begin
            inst_data_ok = !inst_kill;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign inst_rdata = inst_data_ok ? bus_rdata : '0;
  assign data_rdata = data_data_ok ? bus_rdata : '0;
  assign busy       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter (default fixed-priority build).
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        busy;

  int tests;
  int failed;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_wstrb  (data_wstrb),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_wstrb   (bus_wstrb),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b0;
    flush = 1'b0;
    inst_req = 1'b0;
    inst_addr = 32'h0;
    data_req = 1'b0;
    data_wr = 1'b0;
    data_wstrb = 4'h0;
    data_addr = 32'h0;
    data_wdata = 32'h0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;

    // Reset state, with stray memory strobes present
    settle();
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_bus_req", {31'b0, bus_req}, 32'h0);
    chk("rst_data_data_ok", {31'b0, data_data_ok}, 32'h0);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    step();
    rst = 1'b1;
    bus_data_ok = 1'b0;

    // Lone load
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1000_0004;
    settle();
    chk("load_idle_bus_req", {31'b0, bus_req}, 32'h0);
    chk("load_idle_addr_ok", {31'b0, data_addr_ok}, 32'h0);
    step();
    bus_data_ok = 1'b1;
    settle();
    chk("load_addr1_bus_req", {31'b0, bus_req}, 32'h1);
    chk("load_addr1_bus_addr", bus_addr, 32'h1000_0004);
    chk("load_addr1_busy", {31'b0, busy}, 32'h1);
    chk("load_stray_in_addr", {31'b0, data_data_ok}, 32'h0);
    chk("load_addr1_addr_ok", {31'b0, data_addr_ok}, 32'h0);
    step();
    bus_data_ok = 1'b0; bus_addr_ok = 1'b1;
    settle();
    chk("load_addr_ok", {31'b0, data_addr_ok}, 32'h1);
    chk("load_inst_addr_ok", {31'b0, inst_addr_ok}, 32'h0);
    step();
    data_req = 1'b0; bus_addr_ok = 1'b0;
    settle();
    chk("load_resp_bus_req", {31'b0, bus_req}, 32'h0);
    chk("load_resp_wait", {31'b0, data_data_ok}, 32'h0);
    step();
    step();
    bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    settle();
    chk("load_data_ok", {31'b0, data_data_ok}, 32'h1);
    chk("load_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("load_inst_data_ok", {31'b0, inst_data_ok}, 32'h0);
    chk("load_inst_rdata", inst_rdata, 32'h0);
    step();
    settle();
    chk("idle_stray_data_ok", {31'b0, data_data_ok}, 32'h0);
    chk("idle_stray_busy", {31'b0, busy}, 32'h0);
    step();
    bus_data_ok = 1'b0;
    settle();
    chk("idle_stray_stays", {31'b0, busy}, 32'h0);

    // Collision: data store beats inst fetch
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h2000_0000; data_wdata = 32'h0000_1234;
    step();
    bus_addr_ok = 1'b1;
    settle();
    chk("coll_bus_wr", {31'b0, bus_wr}, 32'h1);
    chk("coll_bus_wstrb", {28'b0, bus_wstrb}, 32'h3);
    chk("coll_bus_wdata", bus_wdata, 32'h0000_1234);
    chk("coll_bus_addr", bus_addr, 32'h2000_0000);
    chk("coll_data_addr_ok", {31'b0, data_addr_ok}, 32'h1);
    chk("coll_inst_addr_ok", {31'b0, inst_addr_ok}, 32'h0);
    step();
    data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_0055;
    settle();
    chk("coll_store_done", {31'b0, data_data_ok}, 32'h1);
    step();
    bus_data_ok = 1'b0;
    settle();
    chk("coll_idle_inst_addr_ok", {31'b0, inst_addr_ok}, 32'h0);
    step();
    bus_addr_ok = 1'b1;
    settle();
    chk("coll_inst_bus_addr", bus_addr, 32'hBFC0_0000);
    chk("coll_inst_bus_wr", {31'b0, bus_wr}, 32'h0);
    chk("coll_inst_addr_ok2", {31'b0, inst_addr_ok}, 32'h1);
    step();

    // Flush during inst RESP
    inst_req = 1'b0; bus_addr_ok = 1'b0; flush = 1'b1;
    settle();
    chk("flresp_no_data_ok", {31'b0, inst_data_ok}, 32'h0);
    step();
    flush = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_1111;
    settle();
    chk("flresp_suppressed", {31'b0, inst_data_ok}, 32'h0);
    chk("flresp_rdata", inst_rdata, 32'h0);
    step();
    bus_data_ok = 1'b0;
    settle();
    chk("flresp_back_idle", {31'b0, busy}, 32'h0);

    // Flush in IDLE is ignored and the same-cycle fetch is granted
    flush = 1'b1; inst_req = 1'b1; inst_addr = 32'h0000_0004;
    step();
    flush = 1'b0; bus_addr_ok = 1'b1;
    settle();
    chk("flidle_bus_addr", bus_addr, 32'h0000_0004);
    chk("flidle_addr_ok", {31'b0, inst_addr_ok}, 32'h1);
    step();
    inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_ABCD;
    settle();
    chk("flidle_data_ok", {31'b0, inst_data_ok}, 32'h1);
    chk("flidle_rdata", inst_rdata, 32'h0000_ABCD);
    step();
    bus_data_ok = 1'b0;

    // Flush in inst ADDR suppresses both handshakes
    inst_req = 1'b1; inst_addr = 32'h0000_0008;
    step();
    flush = 1'b1; bus_addr_ok = 1'b1;
    settle();
    chk("fladdr_addr_ok", {31'b0, inst_addr_ok}, 32'h0);
    step();
    inst_req = 1'b0; flush = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    settle();
    chk("fladdr_data_ok", {31'b0, inst_data_ok}, 32'h0);
    chk("fladdr_busy", {31'b0, busy}, 32'h1);
    step();
    bus_data_ok = 1'b0;

    // Flush during a data transaction has no effect
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0030;
    step();
    flush = 1'b1; bus_addr_ok = 1'b1;
    settle();
    chk("fldata_addr_ok", {31'b0, data_addr_ok}, 32'h1);
    step();
    data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_0077;
    settle();
    chk("fldata_data_ok", {31'b0, data_data_ok}, 32'h1);
    chk("fldata_rdata", data_rdata, 32'h0000_0077);
    step();
    flush = 1'b0; bus_data_ok = 1'b0;

    // Asynchronous reset while in ADDR
    data_req = 1'b1; data_addr = 32'h0000_0040;
    step();
    settle();
    chk("rstaddr_bus_req_pre", {31'b0, bus_req}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("rstaddr_bus_req", {31'b0, bus_req}, 32'h0);
    chk("rstaddr_bus_addr", bus_addr, 32'h0);
    chk("rstaddr_busy", {31'b0, busy}, 32'h0);
    step();
    data_req = 1'b0; rst = 1'b1;
    settle();
    chk("rstaddr_idle", {31'b0, busy}, 32'h0);
    step();
    settle();
    chk("rstaddr_stays_idle", {31'b0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
